// File: rtl/rglib_rotate_align_pkg.sv
// Shared types and elaboration helpers for the rotate aligner and its data-path shifter.
package rglib_rotate_align_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  function automatic int unsigned calc_positions(input int unsigned data_width,
                                                 input int unsigned pow_granularity);
    return data_width >> pow_granularity;
  endfunction

  function automatic string opposite_dir(input string dir);
    if (dir == "LEFT") return "RIGHT";
    return "LEFT";
  endfunction

endpackage

// File: rtl/rglib_rotate.sv
// Barrel rotator in coarse steps of 2**POW_GRANULARITY bits with optional output register.
module rglib_rotate
  import rglib_rotate_align_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH       = 32,
  parameter int unsigned          POW_GRANULARITY  = 0,
  parameter string                ROTATE_DIRECTION = "RIGHT",
  parameter int unsigned          ROTATE_STAGE_NUM = $clog2(DATA_WIDTH) - POW_GRANULARITY,
  parameter string                OUT_REG          = "TRUE"
) (
  input  logic                        clk,
  input  logic                        kill,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       in,
  input  logic [ROTATE_STAGE_NUM-1:0] rotate_val,
  output logic                        out_valid,
  output logic [DATA_WIDTH-1:0]       out
);

  localparam int unsigned SHW = ROTATE_STAGE_NUM + POW_GRANULARITY;

  logic [SHW-1:0]        w_shamt;
  logic [SHW:0]          w_compl;
  logic [DATA_WIDTH-1:0] w_rot;

  // A shift by the full width yields zero, so rotate_val=0 needs no special case.
  assign w_shamt = SHW'(rotate_val) << POW_GRANULARITY;
  assign w_compl = (SHW+1)'(DATA_WIDTH) - {1'b0, w_shamt};

  generate
    if (ROTATE_DIRECTION == "LEFT") begin : g_left
      assign w_rot = (in << w_shamt) | (in >> w_compl);
    end else begin : g_right
      assign w_rot = (in >> w_shamt) | (in << w_compl);
    end

    if (OUT_REG == "TRUE") begin : g_reg
      logic                  r_out_valid;
      logic [DATA_WIDTH-1:0] r_out;
      always_ff @(posedge clk) begin
        if (kill) begin
          r_out_valid <= 1'b0;
          r_out       <= '0;
        end else begin
          r_out_valid <= in_valid;
          r_out       <= w_rot;
        end
      end
      assign out_valid = r_out_valid;
      assign out       = r_out;
    end else begin : g_comb
      assign out_valid = in_valid;
      assign out       = w_rot;
    end
  endgenerate

endmodule

// File: rtl/rglib_rotate_align.sv
// Receive aligner: finds the transmitter's rotation via a periodic sync word, locks, de-rotates.
module rglib_rotate_align
  import rglib_rotate_align_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH       = 32,
  parameter int unsigned           POW_GRANULARITY  = 0,
  parameter string                 ROTATE_DIRECTION = "RIGHT",
  parameter int unsigned           ROTATE_STAGE_NUM = $clog2(DATA_WIDTH) - POW_GRANULARITY,
  parameter logic [DATA_WIDTH-1:0] SYNC_PATTERN     = 32'hBC95_0F3A,
  parameter int unsigned           SYNC_PERIOD      = 8,
  parameter int unsigned           LOCK_CNT         = 3,
  parameter int unsigned           UNLOCK_CNT       = 2,
  parameter string                 OUT_REG          = "TRUE"
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        kill,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       in,
  output logic                        out_valid,
  output logic [DATA_WIDTH-1:0]       out,
  output logic                        out_sync,
  output logic                        locked,
  output logic [ROTATE_STAGE_NUM-1:0] rotate_val
);

  localparam int unsigned N         = calc_positions(DATA_WIDTH, POW_GRANULARITY);
  localparam string       DEROT_DIR = opposite_dir(ROTATE_DIRECTION);
  localparam int unsigned PW        = $clog2(SYNC_PERIOD);
  localparam int unsigned HW        = $clog2(LOCK_CNT + 1);
  localparam int unsigned MW        = $clog2(UNLOCK_CNT + 1);

  state_t                      r_state, w_state_nxt;
  logic [PW-1:0]               r_pcnt, w_pcnt_nxt;
  logic [HW-1:0]               r_hit, w_hit_nxt, w_hit_inc;
  logic [MW-1:0]               r_miss, w_miss_nxt, w_miss_inc;
  logic [ROTATE_STAGE_NUM-1:0] r_rotate_val, w_rotate_val_nxt;

  logic [N-1:0]                w_match;
  logic                        w_any;
  logic [ROTATE_STAGE_NUM-1:0] w_cand;
  logic                        w_flush, w_locked, w_check, w_pos_match;
  logic [PW-1:0]               w_pcnt_inc;

  generate
    for (genvar k = 0; k < N; k++) begin : g_match
      localparam int unsigned S = k << POW_GRANULARITY;
      logic [DATA_WIDTH-1:0] w_cand_rot;
      if (S == 0) begin : g_id
        assign w_cand_rot = in;
      end else if (DEROT_DIR == "LEFT") begin : g_left
        assign w_cand_rot = {in[DATA_WIDTH-1-S:0], in[DATA_WIDTH-1:DATA_WIDTH-S]};
      end else begin : g_right
        assign w_cand_rot = {in[S-1:0], in[DATA_WIDTH-1:S]};
      end
      assign w_match[k] = (w_cand_rot == SYNC_PATTERN);
    end
  endgenerate

  always_comb begin
    w_any  = 1'b0;
    w_cand = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (w_match[k] && !w_any) begin
        w_any  = 1'b1;
        w_cand = ROTATE_STAGE_NUM'(k);
      end
    end
  end

  assign w_flush     = kill | ~rst_n;
  assign w_locked    = (r_state == LOCKED);
  assign w_check     = in_valid && (r_pcnt == PW'(SYNC_PERIOD - 1));
  assign w_pos_match = w_match[r_rotate_val];
  assign w_pcnt_inc  = (r_pcnt == PW'(SYNC_PERIOD - 1)) ? '0 : r_pcnt + 1'b1;
  assign w_hit_inc   = r_hit + 1'b1;
  assign w_miss_inc  = r_miss + 1'b1;

  always_comb begin
    w_state_nxt      = r_state;
    w_pcnt_nxt       = r_pcnt;
    w_hit_nxt        = r_hit;
    w_miss_nxt       = r_miss;
    w_rotate_val_nxt = r_rotate_val;
    unique case (r_state)
      SEARCH: begin
        if (in_valid && w_any) begin
          w_rotate_val_nxt = w_cand;
          w_pcnt_nxt       = '0;
          w_hit_nxt        = HW'(1);
          w_miss_nxt       = '0;
          w_state_nxt      = (LOCK_CNT == 1) ? LOCKED : VERIFY;
        end
      end
      VERIFY: begin
        if (in_valid) w_pcnt_nxt = w_pcnt_inc;
        if (w_check) begin
          if (w_pos_match) begin
            w_hit_nxt = w_hit_inc;
            if (w_hit_inc == HW'(LOCK_CNT)) begin
              w_state_nxt = LOCKED;
              w_miss_nxt  = '0;
            end
          end else begin
            w_state_nxt = SEARCH;
            w_hit_nxt   = '0;
            w_pcnt_nxt  = '0;
          end
        end
      end
      LOCKED: begin
        if (in_valid) w_pcnt_nxt = w_pcnt_inc;
        if (w_check) begin
          if (w_pos_match) begin
            w_miss_nxt = '0;
          end else if (w_miss_inc == MW'(UNLOCK_CNT)) begin
            w_state_nxt = SEARCH;
            w_pcnt_nxt  = '0;
            w_hit_nxt   = '0;
            w_miss_nxt  = '0;
          end else begin
            w_miss_nxt = w_miss_inc;
          end
        end
      end
      default: w_state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_state      <= SEARCH;
      r_pcnt       <= '0;
      r_hit        <= '0;
      r_miss       <= '0;
      r_rotate_val <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pcnt       <= w_pcnt_nxt;
      r_hit        <= w_hit_nxt;
      r_miss       <= w_miss_nxt;
      r_rotate_val <= w_rotate_val_nxt;
    end
  end

  // Data path sees the pre-edge lock state and rotation, so entry words are dropped, exit words kept.
  rglib_rotate #(
    .DATA_WIDTH      (DATA_WIDTH),
    .POW_GRANULARITY (POW_GRANULARITY),
    .ROTATE_DIRECTION(DEROT_DIR),
    .ROTATE_STAGE_NUM(ROTATE_STAGE_NUM),
    .OUT_REG         (OUT_REG)
  ) u_rotate (
    .clk       (clk),
    .kill      (w_flush),
    .in_valid  (in_valid & w_locked),
    .in        (in),
    .rotate_val(r_rotate_val),
    .out_valid (out_valid),
    .out       (out)
  );

  generate
    if (OUT_REG == "TRUE") begin : g_sync_reg
      logic r_out_sync;
      always_ff @(posedge clk) begin
        if (w_flush) r_out_sync <= 1'b0;
        else         r_out_sync <= in_valid & w_locked & w_check;
      end
      assign out_sync = r_out_sync;
    end else begin : g_sync_comb
      assign out_sync = in_valid & w_locked & w_check;
    end
  endgenerate

  assign locked     = w_locked;
  assign rotate_val = r_rotate_val;

endmodule

// File: tb/tb_rglib_rotate_align.sv
// Randomized bench for rglib_rotate_align against a word-level reference model.
module tb_rglib_rotate_align;

  localparam logic [31:0] SYNC = 32'hBC95_0F3A;

  logic        clk, rst_n, kill, in_valid;
  logic [31:0] in;
  logic        out_valid, out_sync, locked;
  logic [31:0] out;
  logic [1:0]  rotate_val;

  int checks = 0;
  int passes = 0;

  rglib_rotate_align #(
    .DATA_WIDTH      (32),
    .POW_GRANULARITY (3),
    .ROTATE_DIRECTION("RIGHT"),
    .ROTATE_STAGE_NUM(2),
    .SYNC_PATTERN    (32'hBC95_0F3A),
    .SYNC_PERIOD     (8),
    .LOCK_CNT        (3),
    .UNLOCK_CNT      (2),
    .OUT_REG         ("TRUE")
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .kill      (kill),
    .in_valid  (in_valid),
    .in        (in),
    .out_valid (out_valid),
    .out       (out),
    .out_sync  (out_sync),
    .locked    (locked),
    .rotate_val(rotate_val)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
    logic [63:0] d;
    d = {x, x} << s;
    return d[63:32];
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int s);
    logic [63:0] d;
    d = {x, x} >> s;
    return d[31:0];
  endfunction

  // Reference: mode 0=hunting, 1=confirming, 2=aligned; cnt = valid words since the anchor sync, mod 8.
  int          m_mode, m_rv, m_cnt, m_hits, m_miss;
  bit          m_valid, m_sync, m_out_known, model_ready;
  logic [31:0] m_out;

  task automatic model_step();
    int  cand;
    bit  slot, good;
    if (!rst_n || kill) begin
      m_mode = 0; m_rv = 0; m_cnt = 0; m_hits = 0; m_miss = 0;
      m_valid = 0; m_sync = 0; m_out_known = 1; m_out = '0;
    end else begin
      slot        = in_valid && (m_cnt == 7);
      m_valid     = in_valid && (m_mode == 2);
      m_sync      = m_valid && slot;
      m_out_known = m_valid;
      m_out       = rotl(in, m_rv * 8);
      if (in_valid) begin
        cand = -1;
        for (int k = 3; k >= 0; k--) if (rotl(in, k * 8) == SYNC) cand = k;
        good = (rotl(in, m_rv * 8) == SYNC);
        if (m_mode == 0) begin
          if (cand >= 0) begin
            m_rv = cand; m_cnt = 0; m_hits = 1; m_miss = 0; m_mode = 1;
          end
        end else begin
          m_cnt = (m_cnt + 1) % 8;
          if (slot && m_mode == 1) begin
            if (good) begin
              m_hits++;
              if (m_hits == 3) begin m_mode = 2; m_miss = 0; end
            end else begin
              m_mode = 0; m_hits = 0; m_cnt = 0;
            end
          end else if (slot && m_mode == 2) begin
            if (good) m_miss = 0;
            else begin
              m_miss++;
              if (m_miss == 2) begin m_mode = 0; m_cnt = 0; m_hits = 0; m_miss = 0; end
            end
          end
        end
      end
    end
    model_ready = 1;
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (model_ready) begin
      chk("locked", {31'b0, locked}, {31'b0, m_mode == 2});
      chk("rotate_val", {30'b0, rotate_val}, 32'(m_rv));
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      chk("out_sync", {31'b0, out_sync}, {31'b0, m_sync});
      if (m_out_known) chk("out", out, m_out);
    end
  end

  logic [31:0] origw [0:63];
  bit          s_ov  [0:63];
  bit          s_sy  [0:63];
  bit          s_lk  [0:63];
  logic [31:0] s_out [0:63];

  task automatic send(input logic v, input logic [31:0] d);
    @(negedge clk);
    in_valid = v;
    in       = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    bit          hit;
    do begin
      w   = $urandom;
      hit = 0;
      for (int k = 0; k < 4; k++) if (rotl(w, k * 8) == SYNC) hit = 1;
    end while (hit);
    return w;
  endfunction

  task automatic run_seq(input int rot, input int phase, input int nwords,
                         input int bad0, input int bad1, input int bad2, input int gap_max,
                         output int lock_at, output int unlock_at);
    logic [31:0] w;
    lock_at   = -1;
    unlock_at = -1;
    for (int i = 0; i < nwords; i++) begin
      if (gap_max > 0 && $urandom_range(1, 0) == 1)
        repeat ($urandom_range(gap_max, 1)) send(1'b0, $urandom);
      w = ((i % 8) == phase) ? SYNC : rand_word();
      if (i == bad0 || i == bad1 || i == bad2) w = SYNC ^ 32'h0000_0100;
      origw[i] = w;
      send(1'b1, rotr(w, rot * 8));
      s_ov[i]  = out_valid;
      s_sy[i]  = out_sync;
      s_lk[i]  = locked;
      s_out[i] = out;
      if (lock_at < 0 && locked) lock_at = i;
      if (lock_at >= 0 && unlock_at < 0 && !locked) unlock_at = i;
    end
    send(1'b0, 32'h0);
  endtask

  task automatic flush(input bit use_kill);
    @(negedge clk);
    if (use_kill) kill = 1'b1;
    else          rst_n = 1'b0;
    in_valid = 1'b1;
    in       = SYNC;
    @(posedge clk);
    #1;
    chk("flush_locked", {31'b0, locked}, 32'd0);
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_rotate_val", {30'b0, rotate_val}, 32'd0);
    chk("flush_out", out, 32'd0);
    @(negedge clk);
    kill     = 1'b0;
    rst_n    = 1'b1;
    in_valid = 1'b0;
  endtask

  initial begin
    int la, ua, rot, ph;
    model_ready = 0;
    rst_n = 1'b0; kill = 1'b0; in_valid = 1'b0; in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_locked", {31'b0, locked}, 32'd0);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_out", out, 32'd0);
    chk("reset_rotate_val", {30'b0, rotate_val}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Acquire, transmitter rotated right by two bytes
    run_seq(2, 0, 32, -1, -1, -1, 0, la, ua);
    chk("acq_lock_word", 32'(la), 32'd16);
    chk("acq_rotate_val", {30'b0, rotate_val}, 32'd2);
    chk("acq_entry_not_out", {31'b0, s_ov[16]}, 32'd0);
    chk("acq_w17_valid", {31'b0, s_ov[17]}, 32'd1);
    chk("acq_w17_data", s_out[17], origw[17]);
    chk("acq_w23_nosync", {31'b0, s_sy[23]}, 32'd0);
    chk("acq_w24_sync", {31'b0, s_sy[24]}, 32'd1);

    // Kill flush then zero rotation
    flush(1'b1);
    run_seq(0, 0, 24, -1, -1, -1, 0, la, ua);
    chk("rot0_lock_word", 32'(la), 32'd16);
    chk("rot0_rotate_val", {30'b0, rotate_val}, 32'd0);
    chk("rot0_w20_data", s_out[20], origw[20]);

    // Reset flush then wrap rotation with stalls and a preamble
    flush(1'b0);
    run_seq(3, 3, 40, -1, -1, -1, 5, la, ua);
    chk("rot3_lock_word", 32'(la), 32'd19);
    chk("rot3_rotate_val", {30'b0, rotate_val}, 32'd3);
    chk("rot3_w20_data", s_out[20], origw[20]);

    // Corrupt second sync: back to hunting, re-acquire from word 16
    flush(1'b1);
    run_seq(1, 0, 40, 8, -1, -1, 0, la, ua);
    chk("vfail_lock_word", 32'(la), 32'd32);
    chk("vfail_rotate_val", {30'b0, rotate_val}, 32'd1);

    // Single miss tolerated; two consecutive misses drop lock, exit word still output
    flush(1'b1);
    run_seq(2, 0, 64, 32, 48, 56, 2, la, ua);
    chk("loss_lock_word", 32'(la), 32'd16);
    chk("loss_hold_after_one_miss", {31'b0, s_lk[47]}, 32'd1);
    chk("loss_unlock_word", 32'(ua), 32'd56);
    chk("loss_exit_word_out", {31'b0, s_ov[56]}, 32'd1);
    chk("loss_exit_word_data", s_out[56], origw[56]);

    for (int r = 0; r < 4; r++) begin
      flush(r[0]);
      rot = $urandom_range(3, 0);
      ph  = $urandom_range(7, 0);
      run_seq(rot, ph, 48, -1, -1, -1, 3, la, ua);
      chk("rand_lock_word", 32'(la), 32'(ph + 16));
      chk("rand_rotate_val", {30'b0, rotate_val}, 32'(rot));
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
